// File: rtl/l2_d_cache_types.sv
// Selection enums shared by the L2 data-cache control unit and its datapath muxes.
// Latency: none (type definitions only).
// Backpressure: not applicable.
package l2_d_cache_types;

    typedef enum logic {
        CPU_DATA       = 1'b0,
        LOWER_MEM_DATA = 1'b1
    } d_write_data_selection;

    typedef enum logic {
        CPU_ENABLE = 1'b0,
        ALL_ENABLE = 1'b1
    } d_write_enable_selection;

    typedef enum logic {
        CPU_ADDRESS       = 1'b0,
        LOWER_MEM_ADDRESS = 1'b1
    } d_address_selection;

endpackage

// File: rtl/l2_wb_cache_control.sv
// L2 data-cache controller with a WB_DEPTH-entry write-back buffer draining over a shared memory port.
// Latency: hit responds in the cycle after the request; a miss adds FETCH plus memory time, and EVICT adds 1 cycle.
// Backpressure: a miss stalls in CHK on a buffer address match or when the buffer is full; the memory port is held until pmem_resp_i.
//
// Ports: clk/rst (synchronous, active-high); CPU side mem_read/mem_write -> mem_resp;
// datapath side hit/dirty_out/evicting_way/wb_addr_match in, plus load/valid/dirty/load_lru
// and the data/enable/address selections out; buffer side wb_push, wb_wr_ptr, wb_rd_ptr,
// wb_count, write_back_busy; memory side pmem_read_t/pmem_write_t/hold_arbiter/pmem_resp_i.
// Build option L2_WB_READ_PRIORITY_EN: a pending miss read wins the port over buffer drains.
// Without it, the buffer drains to empty before a miss read is granted.
module l2_wb_cache_control
    import l2_d_cache_types::*;
#(
    parameter  int NUM_WAYS = 4,
    parameter  int WB_DEPTH = 2,
    localparam int WAY_W    = $clog2(NUM_WAYS),
    localparam int PTR_W    = (WB_DEPTH > 1) ? $clog2(WB_DEPTH) : 1,
    localparam int CNT_W    = $clog2(WB_DEPTH + 1)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    mem_read,
    input  logic                    mem_write,
    input  logic                    hit,
    input  logic [NUM_WAYS-1:0]     dirty_out,
    input  logic [WAY_W-1:0]        evicting_way,
    input  logic                    wb_addr_match,
    input  logic                    pmem_resp_i,
    output logic                    mem_resp,
    output logic                    load,
    output logic                    valid,
    output logic                    dirty,
    output logic                    load_lru,
    output d_write_data_selection   write_data_selection_t,
    output d_write_enable_selection write_en_selection_t,
    output d_address_selection      d_address_selection_t,
    output logic                    wb_push,
    output logic [PTR_W-1:0]        wb_wr_ptr,
    output logic [PTR_W-1:0]        wb_rd_ptr,
    output logic [CNT_W-1:0]        wb_count,
    output logic                    write_back_busy,
    output logic                    pmem_read_t,
    output logic                    pmem_write_t,
    output logic                    hold_arbiter
);

    typedef enum logic [2:0] {S_IDLE, S_CHK_R, S_CHK_W, S_EVICT, S_FETCH} state_t;
    typedef enum logic [1:0] {OWN_NONE, OWN_RD, OWN_WR} owner_t;

    state_t state, state_next;
    owner_t owner, owner_next;
    logic   op_write;

    logic victim_dirty, wb_full, read_req, write_req, rd_done, wr_done;

    assign victim_dirty    = dirty_out[evicting_way];
    assign wb_full         = (wb_count == CNT_W'(WB_DEPTH));
    assign read_req        = (state == S_FETCH);
    assign write_req       = (wb_count != '0);
    // A response only means something to whoever owns the port; strays are dropped.
    assign rd_done         = (owner == OWN_RD) && pmem_resp_i;
    assign wr_done         = (owner == OWN_WR) && pmem_resp_i;
    assign write_back_busy = (wb_count != '0);

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(WB_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // State, op and port-owner registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            owner    <= OWN_NONE;
            op_write <= 1'b0;
        end else begin
            state <= state_next;
            owner <= owner_next;
            if (state == S_IDLE && (mem_read || mem_write))
                op_write <= !mem_read;
        end
    end

    // Buffer bookkeeping: a push and a pop in the same cycle leave the count unchanged.
    always_ff @(posedge clk) begin
        if (rst) begin
            wb_wr_ptr <= '0;
            wb_rd_ptr <= '0;
            wb_count  <= '0;
        end else begin
            if (wb_push) wb_wr_ptr <= ptr_inc(wb_wr_ptr);
            if (wr_done) wb_rd_ptr <= ptr_inc(wb_rd_ptr);
            case ({wb_push, wr_done})
                2'b10:   wb_count <= wb_count + 1'b1;
                2'b01:   wb_count <= wb_count - 1'b1;
                default: wb_count <= wb_count;
            endcase
        end
    end

    // Next state
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (mem_read)       state_next = S_CHK_R;
                else if (mem_write) state_next = S_CHK_W;
            end
            S_CHK_R, S_CHK_W: begin
                // An address match must wait for the older copy to reach memory first.
                if (hit)                          state_next = S_IDLE;
                else if (wb_addr_match)           state_next = state;
                else if (victim_dirty && wb_full) state_next = state;
                else if (victim_dirty)            state_next = S_EVICT;
                else                              state_next = S_FETCH;
            end
            S_EVICT: state_next = S_FETCH;
            S_FETCH: begin
                if (rd_done) state_next = op_write ? S_CHK_W : S_CHK_R;
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Port arbitration: a grant is only taken from NONE and held until the response.
    always_comb begin
        owner_next = owner;
        case (owner)
            OWN_NONE: begin
`ifdef L2_WB_READ_PRIORITY_EN
                if (read_req)       owner_next = OWN_RD;
                else if (write_req) owner_next = OWN_WR;
`else
                if (write_req)      owner_next = OWN_WR;
                else if (read_req)  owner_next = OWN_RD;
`endif
            end
            OWN_RD, OWN_WR: begin
                if (pmem_resp_i) owner_next = OWN_NONE;
            end
            default: owner_next = OWN_NONE;
        endcase
    end

    // Outputs
    always_comb begin
        mem_resp               = 1'b0;
        load                   = 1'b0;
        valid                  = 1'b0;
        dirty                  = 1'b0;
        load_lru               = 1'b0;
        wb_push                = 1'b0;
        write_data_selection_t = CPU_DATA;
        write_en_selection_t   = CPU_ENABLE;
        d_address_selection_t  = CPU_ADDRESS;
        pmem_read_t            = 1'b0;
        pmem_write_t           = 1'b0;
        hold_arbiter           = 1'b0;
        case (state)
            S_CHK_R: begin
                if (hit) begin
                    mem_resp = 1'b1;
                    load_lru = 1'b1;
                end
            end
            S_CHK_W: begin
                if (hit) begin
                    mem_resp = 1'b1;
                    load_lru = 1'b1;
                    load     = 1'b1;
                    valid    = 1'b1;
                    dirty    = 1'b1;
                end
            end
            S_EVICT: wb_push = 1'b1;
            S_FETCH: begin
                if (rd_done) begin
                    load                   = 1'b1;
                    valid                  = 1'b1;
                    write_data_selection_t = LOWER_MEM_DATA;
                    write_en_selection_t   = ALL_ENABLE;
                end
            end
            default: ;
        endcase
        case (owner)
            OWN_RD: pmem_read_t = 1'b1;
            OWN_WR: begin
                pmem_write_t          = 1'b1;
                hold_arbiter          = 1'b1;
                d_address_selection_t = LOWER_MEM_ADDRESS;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_l2_wb_cache_control.sv
module tb_l2_wb_cache_control;
    import l2_d_cache_types::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       mem_read = 1'b0, mem_write = 1'b0, hit = 1'b0;
    logic [3:0] dirty_out = 4'b0;
    logic [1:0] evicting_way = 2'b0;
    logic       wb_addr_match = 1'b0, pmem_resp_i = 1'b0;
    logic       mem_resp, load, valid, dirty, load_lru, wb_push;
    logic       wb_wr_ptr, wb_rd_ptr, write_back_busy;
    logic [1:0] wb_count;
    logic       pmem_read_t, pmem_write_t, hold_arbiter;
    d_write_data_selection   wds;
    d_write_enable_selection wes;
    d_address_selection      das;

    int n_chk = 0;
    int n_fail = 0;

    l2_wb_cache_control #(.NUM_WAYS(4), .WB_DEPTH(2)) dut (
        .clk(clk), .rst(rst), .mem_read(mem_read), .mem_write(mem_write), .hit(hit),
        .dirty_out(dirty_out), .evicting_way(evicting_way), .wb_addr_match(wb_addr_match),
        .pmem_resp_i(pmem_resp_i), .mem_resp(mem_resp), .load(load), .valid(valid),
        .dirty(dirty), .load_lru(load_lru), .write_data_selection_t(wds),
        .write_en_selection_t(wes), .d_address_selection_t(das), .wb_push(wb_push),
        .wb_wr_ptr(wb_wr_ptr), .wb_rd_ptr(wb_rd_ptr), .wb_count(wb_count),
        .write_back_busy(write_back_busy), .pmem_read_t(pmem_read_t),
        .pmem_write_t(pmem_write_t), .hold_arbiter(hold_arbiter)
    );

    always #5 clk = ~clk;

    // arr = {mem_resp, load, valid, dirty, load_lru}; pm = {read, write, hold}; sel = {data, en, addr}
    logic [4:0] arr;
    logic [2:0] pm, sel;
    assign arr = {mem_resp, load, valid, dirty, load_lru};
    assign pm  = {pmem_read_t, pmem_write_t, hold_arbiter};
    assign sel = {wds == LOWER_MEM_DATA, wes == ALL_ENABLE, das == LOWER_MEM_ADDRESS};

    task automatic clr_inputs();
        mem_read = 0; mem_write = 0; hit = 0; dirty_out = 4'b0;
        evicting_way = 2'd0; wb_addr_match = 0; pmem_resp_i = 0;
    endtask

    task automatic do_reset();
        @(negedge clk); rst = 1; clr_inputs();
        @(negedge clk); rst = 0;
    endtask

    task automatic test_reset();
        @(negedge clk); #1;
        n_chk++; if ({arr, pm, sel} !== 11'b0) begin n_fail++; $display("FAIL reset_outputs: got %b want %b", {arr, pm, sel}, 11'b0); end
        n_chk++; if ({wb_push, wb_wr_ptr, wb_rd_ptr, wb_count, write_back_busy} !== 6'b0) begin n_fail++; $display("FAIL reset_buffer: got %b want %b", {wb_push, wb_wr_ptr, wb_rd_ptr, wb_count, write_back_busy}, 6'b0); end
        rst = 0;
    endtask

    task automatic test_read_hit();
        do_reset();
        mem_read = 1; hit = 1; #1;
        n_chk++; if (arr !== 5'b00000) begin n_fail++; $display("FAIL rd_hit_idle: got %b want %b", arr, 5'b00000); end
        @(negedge clk); #1;
        n_chk++; if (arr !== 5'b10001) begin n_fail++; $display("FAIL rd_hit_resp: got %b want %b", arr, 5'b10001); end
        @(negedge clk); mem_read = 0; #1;
        n_chk++; if (arr !== 5'b00000) begin n_fail++; $display("FAIL rd_hit_back_idle: got %b want %b", arr, 5'b00000); end
    endtask

    task automatic test_write_hit();
        do_reset();
        mem_write = 1; hit = 1;
        @(negedge clk); #1;
        n_chk++; if (arr !== 5'b11111) begin n_fail++; $display("FAIL wr_hit_resp: got %b want %b", arr, 5'b11111); end
        n_chk++; if (sel !== 3'b000) begin n_fail++; $display("FAIL wr_hit_sel: got %b want %b", sel, 3'b000); end
        @(negedge clk); mem_write = 0; #1;
        n_chk++; if (arr !== 5'b00000) begin n_fail++; $display("FAIL wr_hit_back_idle: got %b want %b", arr, 5'b00000); end
    endtask

    task automatic test_read_wins();
        do_reset();
        mem_read = 1; mem_write = 1; hit = 1;
        @(negedge clk); #1;
        n_chk++; if (arr !== 5'b10001) begin n_fail++; $display("FAIL read_priority: got %b want %b", arr, 5'b10001); end
        @(negedge clk); clr_inputs();
    endtask

    task automatic test_clean_miss();
        do_reset();
        mem_read = 1; dirty_out = 4'b1011; evicting_way = 2'd2;
        @(negedge clk); #1;
        n_chk++; if (arr !== 5'b00000) begin n_fail++; $display("FAIL clean_chk: got %b want %b", arr, 5'b00000); end
        @(negedge clk); #1;
        n_chk++; if ({wb_push, pm} !== 4'b0000) begin n_fail++; $display("FAIL clean_fetch_nogrant: got %b want %b", {wb_push, pm}, 4'b0000); end
        @(negedge clk); pmem_resp_i = 1; hit = 1; #1;
        n_chk++; if (pm !== 3'b100) begin n_fail++; $display("FAIL clean_rd_grant: got %b want %b", pm, 3'b100); end
        n_chk++; if ({arr, sel} !== 8'b01100_110) begin n_fail++; $display("FAIL clean_fill: got %b want %b", {arr, sel}, 8'b01100_110); end
        @(negedge clk); pmem_resp_i = 0; #1;
        n_chk++; if ({arr, pm} !== 8'b10001_000) begin n_fail++; $display("FAIL clean_rechk: got %b want %b", {arr, pm}, 8'b10001_000); end
        @(negedge clk); clr_inputs();
    endtask

    task automatic test_dirty_miss();
        do_reset();
        mem_read = 1; dirty_out = 4'b0100; evicting_way = 2'd2;
        @(negedge clk); #1;
        n_chk++; if ({arr, wb_push} !== 6'b0) begin n_fail++; $display("FAIL dirty_chk: got %b want %b", {arr, wb_push}, 6'b0); end
        @(negedge clk); #1;
        n_chk++; if ({wb_push, wb_wr_ptr, wb_count} !== 4'b1000) begin n_fail++; $display("FAIL dirty_evict: got %b want %b", {wb_push, wb_wr_ptr, wb_count}, 4'b1000); end
        @(negedge clk); #1;
        n_chk++; if ({wb_push, wb_wr_ptr, wb_count, write_back_busy, pm} !== 8'b0_1_01_1_000) begin n_fail++; $display("FAIL dirty_fetch: got %b want %b", {wb_push, wb_wr_ptr, wb_count, write_back_busy, pm}, 8'b0_1_01_1_000); end
`ifdef L2_WB_READ_PRIORITY_EN
        @(negedge clk); pmem_resp_i = 1; hit = 1; #1;
        n_chk++; if ({pm, arr} !== 8'b100_01100) begin n_fail++; $display("FAIL prio_rd_first: got %b want %b", {pm, arr}, 8'b100_01100); end
        @(negedge clk); pmem_resp_i = 0; #1;
        n_chk++; if ({arr, pm, wb_count} !== 10'b10001_000_01) begin n_fail++; $display("FAIL prio_rechk: got %b want %b", {arr, pm, wb_count}, 10'b10001_000_01); end
        @(negedge clk); mem_read = 0; #1;
        n_chk++; if ({pm, sel} !== 6'b011_001) begin n_fail++; $display("FAIL prio_wr_grant: got %b want %b", {pm, sel}, 6'b011_001); end
        @(negedge clk); pmem_resp_i = 1; #1;
        n_chk++; if (wb_count !== 2'd1) begin n_fail++; $display("FAIL prio_cnt_before_pop: got %0d want %0d", wb_count, 1); end
        @(negedge clk); pmem_resp_i = 0; #1;
        n_chk++; if ({wb_count, wb_rd_ptr, write_back_busy, pm} !== 7'b00_1_0_000) begin n_fail++; $display("FAIL prio_drained: got %b want %b", {wb_count, wb_rd_ptr, write_back_busy, pm}, 7'b00_1_0_000); end
`else
        @(negedge clk); #1;
        n_chk++; if ({pm, sel} !== 6'b011_001) begin n_fail++; $display("FAIL strict_wr_first: got %b want %b", {pm, sel}, 6'b011_001); end
        @(negedge clk); pmem_resp_i = 1; #1;
        n_chk++; if (pm !== 3'b011) begin n_fail++; $display("FAIL strict_wr_hold: got %b want %b", pm, 3'b011); end
        @(negedge clk); pmem_resp_i = 0; #1;
        n_chk++; if ({wb_count, wb_rd_ptr, pm} !== 6'b00_1_000) begin n_fail++; $display("FAIL strict_drained: got %b want %b", {wb_count, wb_rd_ptr, pm}, 6'b00_1_000); end
        @(negedge clk); pmem_resp_i = 1; hit = 1; #1;
        n_chk++; if ({pm, arr} !== 8'b100_01100) begin n_fail++; $display("FAIL strict_rd_after: got %b want %b", {pm, arr}, 8'b100_01100); end
        @(negedge clk); pmem_resp_i = 0; #1;
        n_chk++; if (arr !== 5'b10001) begin n_fail++; $display("FAIL strict_rechk: got %b want %b", arr, 5'b10001); end
`endif
        @(negedge clk); clr_inputs();
    endtask

    task automatic test_addr_match();
        do_reset();
        mem_read = 1; dirty_out = 4'b0100; evicting_way = 2'd2; wb_addr_match = 1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (i == 3) wb_addr_match = 0;
            #1;
            n_chk++; if ({wb_push, pm, arr} !== 9'b0) begin n_fail++; $display("FAIL match_stall_%0d: got %b want %b", i, {wb_push, pm, arr}, 9'b0); end
        end
        @(negedge clk); #1;
        n_chk++; if (wb_push !== 1'b1) begin n_fail++; $display("FAIL match_release: got %b want %b", wb_push, 1'b1); end
        @(negedge clk); clr_inputs();
    endtask

    task automatic test_stray_resp();
        do_reset();
        pmem_resp_i = 1;
        @(negedge clk); #1;
        n_chk++; if ({wb_count, wb_rd_ptr} !== 3'b000) begin n_fail++; $display("FAIL stray_idle: got %b want %b", {wb_count, wb_rd_ptr}, 3'b000); end
        pmem_resp_i = 0; mem_read = 1; dirty_out = 4'b0000;
        @(negedge clk);
        @(negedge clk); pmem_resp_i = 1; #1;
        n_chk++; if (arr !== 5'b00000) begin n_fail++; $display("FAIL stray_fetch_noload: got %b want %b", arr, 5'b00000); end
        @(negedge clk); pmem_resp_i = 0; #1;
        n_chk++; if (pm !== 3'b100) begin n_fail++; $display("FAIL stray_fetch_grant: got %b want %b", pm, 3'b100); end
        @(negedge clk); clr_inputs();
    endtask

    task automatic test_reset_mid();
        do_reset();
        mem_read = 1; dirty_out = 4'b0100; evicting_way = 2'd2;
        repeat (4) @(negedge clk);
        #1;
`ifdef L2_WB_READ_PRIORITY_EN
        n_chk++; if (pm !== 3'b100) begin n_fail++; $display("FAIL rstmid_owner: got %b want %b", pm, 3'b100); end
`else
        n_chk++; if (pm !== 3'b011) begin n_fail++; $display("FAIL rstmid_owner: got %b want %b", pm, 3'b011); end
`endif
        rst = 1; mem_read = 0;
        @(negedge clk); rst = 0; hit = 1; #1;
        n_chk++; if ({wb_count, wb_wr_ptr, wb_rd_ptr, write_back_busy, pm} !== 8'b0) begin n_fail++; $display("FAIL rstmid_cleared: got %b want %b", {wb_count, wb_wr_ptr, wb_rd_ptr, write_back_busy, pm}, 8'b0); end
        n_chk++; if (arr !== 5'b00000) begin n_fail++; $display("FAIL rstmid_idle: got %b want %b", arr, 5'b00000); end
        @(negedge clk); #1;
        n_chk++; if ({arr, pm} !== 8'b0) begin n_fail++; $display("FAIL rstmid_next: got %b want %b", {arr, pm}, 8'b0); end
        clr_inputs();
    endtask

`ifdef L2_WB_READ_PRIORITY_EN
    task automatic test_back_to_back();
        do_reset();
        mem_read = 1; dirty_out = 4'b0100; evicting_way = 2'd2;
        repeat (4) @(negedge clk);
        pmem_resp_i = 1; hit = 1;
        @(negedge clk); pmem_resp_i = 0;
        @(negedge clk); hit = 0; #1;
        n_chk++; if (pm !== 3'b011) begin n_fail++; $display("FAIL b2b_wr_a: got %b want %b", pm, 3'b011); end
        repeat (3) @(negedge clk);
        #1;
        n_chk++; if ({wb_count, wb_wr_ptr, pm} !== 6'b10_0_011) begin n_fail++; $display("FAIL b2b_full: got %b want %b", {wb_count, wb_wr_ptr, pm}, 6'b10_0_011); end
        @(negedge clk); pmem_resp_i = 1; #1;
        n_chk++; if (pm !== 3'b011) begin n_fail++; $display("FAIL b2b_no_rd_while_wr: got %b want %b", pm, 3'b011); end
        @(negedge clk); pmem_resp_i = 0; #1;
        n_chk++; if ({wb_count, wb_rd_ptr, pm} !== 6'b01_1_000) begin n_fail++; $display("FAIL b2b_pop_a: got %b want %b", {wb_count, wb_rd_ptr, pm}, 6'b01_1_000); end
        @(negedge clk); pmem_resp_i = 1; hit = 1;
        @(negedge clk); pmem_resp_i = 0;
        @(negedge clk); hit = 0;
        @(negedge clk);
        @(negedge clk); pmem_resp_i = 1; #1;
        n_chk++; if ({wb_push, wb_count, pm} !== 6'b1_01_011) begin n_fail++; $display("FAIL b2b_push_pop: got %b want %b", {wb_push, wb_count, pm}, 6'b1_01_011); end
        @(negedge clk); pmem_resp_i = 0; #1;
        n_chk++; if ({wb_count, wb_wr_ptr, wb_rd_ptr} !== 4'b01_1_0) begin n_fail++; $display("FAIL b2b_cnt_kept: got %b want %b", {wb_count, wb_wr_ptr, wb_rd_ptr}, 4'b01_1_0); end
        clr_inputs();
    endtask
`endif

    initial begin
        test_reset();
        test_read_hit();
        test_write_hit();
        test_read_wins();
        test_clean_miss();
        test_dirty_miss();
        test_addr_match();
        test_stray_resp();
        test_reset_mid();
`ifdef L2_WB_READ_PRIORITY_EN
        test_back_to_back();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
